mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register; sits directly downstream of the EX/MEM latch and feeds writeback.
- Drives the data-cache request (dmemREN/dmemWEN/addr/store) and holds it until dhit.
- Generates the pipeline stall while a load/store is outstanding.
- Selects the writeback value, registers it for WB, exports a forwarding tap for EX, and makes halt sticky.

Parameters:
WORD_W, 32, datapath/word width
REGSEL_W, 5, register-select width

Ports:
CLK  input  1  system clock
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch hit; pipeline may advance only when 1
dREN_in  input  1  load request from EX/MEM
dWEN_in  input  1  store request from EX/MEM
portO_in  input  WORD_W  ALU result / effective address
dmemstore_in  input  WORD_W  store data
RegWr_in  input  1  register write enable
MemToReg_in  input  2  writeback select: 0 ALU, 1 load, 2 LUI, 3 PC+4
luiValue_in  input  WORD_W  LUI immediate value
pcp4_in  input  WORD_W  PC+4 for JAL
wsel_in  input  REGSEL_W  destination register
halt_in  input  1  halt instruction in MEM
dhit  input  1  data cache completed access this cycle
dmemload  input  WORD_W  load data, valid only when dhit=1
dmemREN  output  1  cache read request
dmemWEN  output  1  cache write request
dmemaddr  output  WORD_W  cache address (= portO_in)
dmemstore  output  WORD_W  cache store data (= dmemstore_in)
mem_stall  output  1  freeze IF/ID/EX and EX/MEM
wdat_out  output  WORD_W  registered writeback data
wsel_out  output  REGSEL_W  registered destination
RegWr_out  output  1  registered write enable
halt_out  output  1  sticky halt to datapath/system
fwd_valid  output  1  combinational: MEM-stage result forwardable (RegWr_in & MemToReg_in!=1)
fwd_data  output  WORD_W  combinational MEM-stage value for EX forwarding
fwd_wsel  output  REGSEL_W  combinational destination of MEM-stage instruction

Behaviour:
- Reset (nRST=0, async): state IDLE; ld_hold=0; wdat_out/wsel_out/RegWr_out/halt_out=0. Reset mid-access returns to IDLE and drops dmemREN/dmemWEN immediately.
- mem_op = (dREN_in | dWEN_in) & ~halt_out.
- FSM states:
  - IDLE: if mem_op, assert request combinationally this cycle and go to WAIT unless dhit already.
  - WAIT: hold request; on dhit capture dmemload into ld_hold (loads); go to DONE if ~ihit, else IDLE (advance).
  - DONE: request deasserted, no repeat access; wait for ihit then IDLE.
- dmemREN = dREN_in & mem_op & (state!=DONE); dmemWEN likewise with dWEN_in. REN and WEN are never both 1; if both inputs are set, WEN wins.
- Stall and advance:
  - mem_stall = mem_op & ~dhit & (state!=DONE).
  - advance = ihit & ~mem_stall & ~halt_out.
- Load data: loaddata = dhit ? dmemload : ld_hold.
- wdat mux by MemToReg_in: 0 portO_in, 1 loaddata, 2 luiValue_in, 3 pcp4_in.
- MEM/WB register: on advance, capture wdat/wsel/RegWr/halt_in; otherwise hold. Latency is 1 cycle after the advancing edge.
- Bubble: if ihit=0 or stalled, RegWr_out is unchanged (register holds). No duplicate write, because WB writes on the same advance.
- halt_out: once set, it stays 1 until reset, the register freezes, and no further cache requests are made.
- Simultaneous dhit & ihit in WAIT: single-cycle completion, with no DONE visit.
- dhit while in IDLE with no request: ignored.

Decomposition:
- cpu_types_pkg: word_t, regbits_t, memtoreg_t enum {MTR_ALU, MTR_MEM, MTR_LUI, MTR_PC4}, memstate_t enum {IDLE, WAIT, DONE}.
- One sub-module, mem_access_fsm: state, ld_hold, request/stall generation. The top level holds the mux and the MEM/WB register.

Test Plan:
- Reset mid-WAIT with dREN_in=1 → dmemREN=0, mem_stall=0 and all outputs 0 immediately; state IDLE after release.
- ALU op: MemToReg=0, portO_in=0x1234, wsel=5, RegWr=1, ihit=1 → next cycle wdat_out=0x1234, wsel_out=5, RegWr_out=1, no dmemREN.
- Load with dhit 3 cycles late, dmemload=0xDEADBEEF, ihit=1 → mem_stall=1 for 3 cycles, dmemREN=1 throughout, then wdat_out=0xDEADBEEF.
- Store: dhit at cycle 1 while ihit=0 until cycle 4 → dmemWEN=1 only in cycles 0–1, DONE in cycles 2–3, a single write, RegWr_out=0.
- Load: dhit & ihit same cycle, dmemload=0xA5 → no DONE state, wdat_out=0xA5 next cycle.
- halt_in=1 with ihit=1 → halt_out=1 permanently; a later dREN_in=1 produces no dmemREN and outputs stay frozen.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the memory stage: word/register-select
// types, the writeback-source select and the data-access FSM states.
package cpu_types_pkg;

    localparam int WORD_BITS   = 32;
    localparam int REGSEL_BITS = 5;

    typedef logic [WORD_BITS-1:0]   word_t;
    typedef logic [REGSEL_BITS-1:0] regbits_t;

    // Writeback source: ALU result, load data, LUI immediate, PC+4 (JAL).
    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_LUI = 2'd2,
        MTR_PC4 = 2'd3
    } memtoreg_t;

    // IDLE: no access in flight; WAIT: request held until dhit;
    // DONE: access finished but the pipeline has not advanced yet.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memstate_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-cache access sequencer: drives the read/write request, holds it
// until the cache answers, keeps load data until the pipeline advances,
// and raises the stall while an access is outstanding.
module mem_access_fsm
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ihit_i,
    input  logic              dren_i,
    input  logic              dwen_i,
    input  logic              halt_i,
    input  logic              dhit_i,
    input  logic [WORD_W-1:0] dmemload_i,
    output logic              dmem_ren_o,
    output logic              dmem_wen_o,
    output logic              mem_stall_o,
    output logic [WORD_W-1:0] loaddata_o
);

    memstate_t         state_q, state_d;
    logic [WORD_W-1:0] ld_hold_q, ld_hold_d;
    logic              mem_op;
    logic              req_ok;
    logic              is_load;

    // Request/stall generation and next-state logic; requests are also
    // gated by reset so an access in flight is dropped the moment reset hits.
    always_comb begin
        mem_op      = (dren_i | dwen_i) & ~halt_i & rst_ni;
        req_ok      = mem_op & (state_q != DONE);
        is_load     = dren_i & ~dwen_i;
        dmem_wen_o  = req_ok & dwen_i;
        dmem_ren_o  = req_ok & is_load;
        mem_stall_o = req_ok & ~dhit_i;
        loaddata_o  = dhit_i ? dmemload_i : ld_hold_q;
        state_d     = state_q;
        ld_hold_d   = ld_hold_q;
        case (state_q)
            IDLE, WAIT: begin
                if (mem_op) begin
                    if (dhit_i) begin
                        if (is_load) begin
                            ld_hold_d = dmemload_i;
                        end
                        // Finished access: advance now, or park in DONE so the
                        // same access is not issued again while IF stalls.
                        state_d = ihit_i ? IDLE : DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (ihit_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and held load data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ld_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_hold_q <= ld_hold_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: issues the data-cache
// access, selects the writeback value, registers it for WB, exports a
// forwarding tap for EX and keeps halt sticky.
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int REGSEL_W = 5
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                ihit,
    input  logic                dREN_in,
    input  logic                dWEN_in,
    input  logic [WORD_W-1:0]   portO_in,
    input  logic [WORD_W-1:0]   dmemstore_in,
    input  logic                RegWr_in,
    input  logic [1:0]          MemToReg_in,
    input  logic [WORD_W-1:0]   luiValue_in,
    input  logic [WORD_W-1:0]   pcp4_in,
    input  logic [REGSEL_W-1:0] wsel_in,
    input  logic                halt_in,
    input  logic                dhit,
    input  logic [WORD_W-1:0]   dmemload,
    output logic                dmemREN,
    output logic                dmemWEN,
    output logic [WORD_W-1:0]   dmemaddr,
    output logic [WORD_W-1:0]   dmemstore,
    output logic                mem_stall,
    output logic [WORD_W-1:0]   wdat_out,
    output logic [REGSEL_W-1:0] wsel_out,
    output logic                RegWr_out,
    output logic                halt_out,
    output logic                fwd_valid,
    output logic [WORD_W-1:0]   fwd_data,
    output logic [REGSEL_W-1:0] fwd_wsel
);

    logic [WORD_W-1:0]   loaddata;
    logic [WORD_W-1:0]   wdat_d, wdat_q;
    logic [REGSEL_W-1:0] wsel_q;
    logic                regwr_q;
    logic                halt_q;
    logic                advance;

    mem_access_fsm #(
        .WORD_W (WORD_W)
    ) u_fsm (
        .clk_i       (CLK),
        .rst_ni      (nRST),
        .ihit_i      (ihit),
        .dren_i      (dREN_in),
        .dwen_i      (dWEN_in),
        .halt_i      (halt_q),
        .dhit_i      (dhit),
        .dmemload_i  (dmemload),
        .dmem_ren_o  (dmemREN),
        .dmem_wen_o  (dmemWEN),
        .mem_stall_o (mem_stall),
        .loaddata_o  (loaddata)
    );

    assign dmemaddr  = portO_in;
    assign dmemstore = dmemstore_in;

    // Writeback value select; load results come from the cache or the hold register.
    always_comb begin
        wdat_d = portO_in;
        case (memtoreg_t'(MemToReg_in))
            MTR_ALU: wdat_d = portO_in;
            MTR_MEM: wdat_d = loaddata;
            MTR_LUI: wdat_d = luiValue_in;
            MTR_PC4: wdat_d = pcp4_in;
            default: wdat_d = portO_in;
        endcase
    end

    // A halted pipeline never advances, which also makes halt_q sticky.
    assign advance = ihit & ~mem_stall & ~halt_q;

    // MEM/WB register: captures only on advance, otherwise holds (no duplicate write).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdat_q  <= '0;
            wsel_q  <= '0;
            regwr_q <= 1'b0;
            halt_q  <= 1'b0;
        end else if (advance) begin
            wdat_q  <= wdat_d;
            wsel_q  <= wsel_in;
            regwr_q <= RegWr_in;
            halt_q  <= halt_in;
        end
    end

    assign wdat_out  = wdat_q;
    assign wsel_out  = wsel_q;
    assign RegWr_out = regwr_q;
    assign halt_out  = halt_q;

    // Load results are not known early enough to forward from MEM.
    assign fwd_valid = RegWr_in & (memtoreg_t'(MemToReg_in) != MTR_MEM);
    assign fwd_data  = wdat_d;
    assign fwd_wsel  = wsel_in;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;
    import cpu_types_pkg::*;

    logic        CLK, nRST, ihit, dREN_in, dWEN_in, RegWr_in, halt_in, dhit;
    logic [31:0] portO_in, dmemstore_in, luiValue_in, pcp4_in, dmemload;
    logic [1:0]  MemToReg_in;
    logic [4:0]  wsel_in;
    logic        dmemREN, dmemWEN, mem_stall, RegWr_out, halt_out, fwd_valid;
    logic [31:0] dmemaddr, dmemstore, wdat_out, fwd_data;
    logic [4:0]  wsel_out, fwd_wsel;

    int n_checks = 0;
    int n_pass   = 0;

    mem_wb_stage #(.WORD_W(32), .REGSEL_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .portO_in(portO_in), .dmemstore_in(dmemstore_in), .RegWr_in(RegWr_in),
        .MemToReg_in(MemToReg_in), .luiValue_in(luiValue_in), .pcp4_in(pcp4_in),
        .wsel_in(wsel_in), .halt_in(halt_in), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .wdat_out(wdat_out), .wsel_out(wsel_out),
        .RegWr_out(RegWr_out), .halt_out(halt_out), .fwd_valid(fwd_valid),
        .fwd_data(fwd_data), .fwd_wsel(fwd_wsel)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        dREN_in = 0; dWEN_in = 0; RegWr_in = 0; halt_in = 0; dhit = 0;
        MemToReg_in = 2'd0; wsel_in = 5'd0; portO_in = 0; dmemstore_in = 0;
        luiValue_in = 0; pcp4_in = 0; dmemload = 0;
    endtask

    initial begin
        nRST = 0; ihit = 0;
        idle_inputs();
        tick(); tick();
        check("rst_wdat", wdat_out, 0);
        check("rst_regwr", {31'd0, RegWr_out}, 0);
        check("rst_halt", {31'd0, halt_out}, 0);
        nRST = 1;

        // ALU op
        ihit = 1; RegWr_in = 1; MemToReg_in = 2'd0; portO_in = 32'h1234; wsel_in = 5'd5;
        #1;
        check("alu_fwd_valid", {31'd0, fwd_valid}, 1);
        check("alu_fwd_data", fwd_data, 32'h1234);
        check("alu_ren", {31'd0, dmemREN}, 0);
        tick();
        check("alu_wdat", wdat_out, 32'h1234);
        check("alu_wsel", {27'd0, wsel_out}, 5);
        check("alu_regwr", {31'd0, RegWr_out}, 1);

        // ihit low: register holds
        ihit = 0; portO_in = 32'h5555; wsel_in = 5'd6; RegWr_in = 0;
        tick();
        check("bubble_wdat", wdat_out, 32'h1234);
        check("bubble_regwr", {31'd0, RegWr_out}, 1);

        // LUI and PC+4 selects
        ihit = 1; RegWr_in = 1; MemToReg_in = 2'd2; luiValue_in = 32'hABCD0000; wsel_in = 5'd7;
        tick();
        check("lui_wdat", wdat_out, 32'hABCD0000);
        MemToReg_in = 2'd3; pcp4_in = 32'h44; wsel_in = 5'd31;
        tick();
        check("pc4_wdat", wdat_out, 32'h44);
        check("pc4_wsel", {27'd0, wsel_out}, 31);

        // Load with dhit three cycles late
        dREN_in = 1; MemToReg_in = 2'd1; wsel_in = 5'd9; portO_in = 32'h100; dhit = 0;
        #1;
        check("ld_fwd_valid", {31'd0, fwd_valid}, 0);
        check("ld_addr", dmemaddr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            check("ld_stall", {31'd0, mem_stall}, 1);
            check("ld_ren", {31'd0, dmemREN}, 1);
            tick();
        end
        check("ld_wdat_held", wdat_out, 32'h44);
        dhit = 1; dmemload = 32'hDEADBEEF;
        #1;
        check("ld_hit_stall", {31'd0, mem_stall}, 0);
        check("ld_hit_ren", {31'd0, dmemREN}, 1);
        tick();
        dREN_in = 0; dhit = 0; dmemload = 0;
        check("ld_wdat", wdat_out, 32'hDEADBEEF);
        check("ld_wsel", {27'd0, wsel_out}, 9);

        // Store: dhit in cycle 1, ihit low until cycle 4
        ihit = 0; dWEN_in = 1; RegWr_in = 0; MemToReg_in = 2'd0;
        portO_in = 32'h200; dmemstore_in = 32'h55;
        #1;
        check("st_wen0", {31'd0, dmemWEN}, 1);
        check("st_ren0", {31'd0, dmemREN}, 0);
        check("st_data", dmemstore, 32'h55);
        check("st_stall0", {31'd0, mem_stall}, 1);
        tick();
        dhit = 1;
        #1;
        check("st_wen1", {31'd0, dmemWEN}, 1);
        check("st_stall1", {31'd0, mem_stall}, 0);
        tick();
        dhit = 0;
        for (int i = 2; i < 4; i++) begin
            check("st_done_wen", {31'd0, dmemWEN}, 0);
            check("st_done_state", 32'(dut.u_fsm.state_q), 32'(DONE));
            tick();
        end
        check("st_regwr_hold", {31'd0, RegWr_out}, 1);
        ihit = 1;
        #1;
        check("st_wen4", {31'd0, dmemWEN}, 0);
        tick();
        dWEN_in = 0;
        check("st_regwr", {31'd0, RegWr_out}, 0);
        check("st_wdat", wdat_out, 32'h200);

        // Load finishing with dhit and ihit together in WAIT
        dREN_in = 1; MemToReg_in = 2'd1; RegWr_in = 1; wsel_in = 5'd3; dhit = 0;
        tick();
        dhit = 1; dmemload = 32'hA5;
        tick();
        check("ldh_wdat", wdat_out, 32'hA5);
        check("ldh_state", 32'(dut.u_fsm.state_q), 32'(IDLE));
        dhit = 0; dmemload = 0;
        #1;
        check("ldh_next_ren", {31'd0, dmemREN}, 1);
        check("ldh_next_stall", {31'd0, mem_stall}, 1);
        dhit = 1; dmemload = 32'h77;
        tick();
        check("ldh_next_wdat", wdat_out, 32'h77);
        dREN_in = 0; dhit = 0;

        // Halt becomes sticky and freezes everything
        halt_in = 1; RegWr_in = 0; MemToReg_in = 2'd0; portO_in = 32'h999;
        tick();
        check("halt_set", {31'd0, halt_out}, 1);
        check("halt_wdat", wdat_out, 32'h999);
        halt_in = 0; portO_in = 32'h888; RegWr_in = 1; dREN_in = 1; MemToReg_in = 2'd0;
        #1;
        check("halt_ren", {31'd0, dmemREN}, 0);
        check("halt_stall", {31'd0, mem_stall}, 0);
        tick(); tick();
        check("halt_sticky", {31'd0, halt_out}, 1);
        check("halt_frozen_wdat", wdat_out, 32'h999);
        check("halt_frozen_regwr", {31'd0, RegWr_out}, 0);

        // Reset in the middle of a load in WAIT
        dREN_in = 0; nRST = 0;
        tick();
        nRST = 1;
        dREN_in = 1; dhit = 0; MemToReg_in = 2'd1; wsel_in = 5'd4; RegWr_in = 1; portO_in = 32'h300;
        tick();
        check("mrst_wait_ren", {31'd0, dmemREN}, 1);
        check("mrst_wait_state", 32'(dut.u_fsm.state_q), 32'(WAIT));
        nRST = 0;
        #1;
        check("mrst_ren", {31'd0, dmemREN}, 0);
        check("mrst_stall", {31'd0, mem_stall}, 0);
        check("mrst_wdat", wdat_out, 0);
        check("mrst_regwr", {31'd0, RegWr_out}, 0);
        check("mrst_halt", {31'd0, halt_out}, 0);
        dREN_in = 0;
        tick();
        nRST = 1;
        #1;
        check("mrst_state", 32'(dut.u_fsm.state_q), 32'(IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
